// File: rtl/ni_tx_1of4_if.sv
// PE-side word handshake and router-side 1-of-4 rails with eof and ack, grouped for the transmitter.
interface ni_tx_1of4_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned SCN = DW / 2
);
  logic [DW-1:0]  in_data;
  logic           in_eop;
  logic           in_valid;
  logic           in_ready;
  logic [SCN-1:0] o0;
  logic [SCN-1:0] o1;
  logic [SCN-1:0] o2;
  logic [SCN-1:0] o3;
  logic           o4;
  logic           ia;
  logic           busy;
  logic [15:0]    pkt_cnt;

  modport slave (
    input  in_data, in_eop, in_valid, ia,
    output in_ready, o0, o1, o2, o3, o4, busy, pkt_cnt
  );

  modport master (
    output in_data, in_eop, in_valid, ia,
    input  in_ready, o0, o1, o2, o3, o4, busy, pkt_cnt
  );
endinterface

// File: rtl/ni_tx_1of4.sv
// Clocked-to-asynchronous transmitter: encodes each accepted word as one 1-of-4 flit, runs a
// four-phase RTZ handshake on a synchronised ack and appends an eof token after each packet.
module ni_tx_1of4 #(
  parameter int unsigned DW   = 32,
  parameter int unsigned SCN  = DW / 2,
  parameter int unsigned SYNC = 2
) (
  input logic         clk,
  input logic         rst,
  ni_tx_1of4_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StData, StDnull, StEof, StEnull} state_e;

  state_e         state_q, state_d;
  logic [SYNC-1:0] sync_q;
  logic           ack_s;
  logic           accept;
  logic [DW-1:0]  word_q, word_d;
  logic           eop_q, eop_d;
  logic [SCN-1:0] o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
  logic           o4_q, o4_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;

  assign ack_s  = sync_q[SYNC-1];
  assign accept = bus.in_valid & ready_q;

  assign bus.o0       = o0_q;
  assign bus.o1       = o1_q;
  assign bus.o2       = o2_q;
  assign bus.o3       = o3_q;
  assign bus.o4       = o4_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.pkt_cnt  = pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      word_q    <= '0;
      eop_q     <= 1'b0;
      o0_q      <= '0;
      o1_q      <= '0;
      o2_q      <= '0;
      o3_q      <= '0;
      o4_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC-2:0], bus.ia};
      word_q    <= word_d;
      eop_q     <= eop_d;
      o0_q      <= o0_d;
      o1_q      <= o1_d;
      o2_q      <= o2_d;
      o3_q      <= o3_d;
      o4_q      <= o4_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StData;
      StData:  if (ack_s) state_d = StDnull;
      StDnull: if (!ack_s) state_d = eop_q ? StEof : StIdle;
      StEof:   if (ack_s) state_d = StEnull;
      StEnull: if (!ack_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Every output is computed from the next state so the registered rails move on that edge only.
  always_comb begin
    word_d = word_q;
    eop_d  = eop_q;
    if (accept) begin
      word_d = bus.in_data;
      eop_d  = bus.in_eop;
    end

    o0_d = '0;
    o1_d = '0;
    o2_d = '0;
    o3_d = '0;
    if (state_d == StData) begin
      for (int k = 0; k < SCN; k++) begin
        unique case (word_d[2*k +: 2])
          2'd0: o0_d[k] = 1'b1;
          2'd1: o1_d[k] = 1'b1;
          2'd2: o2_d[k] = 1'b1;
          2'd3: o3_d[k] = 1'b1;
          default: o0_d[k] = 1'b1;
        endcase
      end
    end

    o4_d   = (state_d == StEof);
    busy_d = (state_d != StIdle);
    // Ready only opens once IDLE has been seen with a released ack, never on the accept edge.
    ready_d   = (state_q == StIdle) && (state_d == StIdle) && !ack_s;
    pkt_cnt_d = pkt_cnt_q;
    if ((state_q == StEnull) && (state_d == StIdle)) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_ni_tx_1of4.sv
// Directed bench for ni_tx_1of4: zero-delay and slow ack models, stale ack, reset and wrap cases.
module tb_ni_tx_1of4;
  localparam int unsigned DW   = 32;
  localparam int unsigned SCN  = 16;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ni_tx_1of4_if #(.DW(DW), .SCN(SCN)) bus ();

  ni_tx_1of4 #(.DW(DW), .SCN(SCN), .SYNC(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Ack models: 0 follows rails with zero delay, 1 follows rails 10 cycles late, 2 manual.
  int   ack_mode = 0;
  logic ia_man   = 1'b0;
  logic ia_dly   = 1'b0;
  int   dly_cnt  = 0;
  logic rails_any;
  assign rails_any = |{bus.o0, bus.o1, bus.o2, bus.o3, bus.o4};
  assign bus.ia = (ack_mode == 0) ? rails_any : (ack_mode == 1) ? ia_dly : ia_man;

  always @(posedge clk) begin
    if (rails_any != ia_dly) begin
      if (dly_cnt == 9) begin
        ia_dly  <= rails_any;
        dly_cnt <= 0;
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      dly_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor state, sampled on each negedge through tick().
  int          cyc = 0;
  logic        mon_en = 1'b0;
  int          oh_err, eof_cnt, rail_chg, rdy_busy, data_cyc, eof_cyc;
  logic [64:0] prev;
  logic        prev_any, prev_o4;
  logic [31:0] dec_q[$];

  task automatic mon_reset();
    oh_err = 0; eof_cnt = 0; rail_chg = 0; rdy_busy = 0; data_cyc = 0; eof_cyc = 0;
    prev = '0; prev_any = 1'b0; prev_o4 = 1'b0;
    dec_q.delete();
  endtask

  task automatic mon_sample();
    logic [64:0] cur;
    logic [31:0] w;
    logic        any;
    int          n;
    cur = {bus.o3, bus.o2, bus.o1, bus.o0, bus.o4};
    any = |cur[64:1];
    if (any) begin
      data_cyc++;
      w = '0;
      for (int k = 0; k < int'(SCN); k++) begin
        n = int'(bus.o0[k]) + int'(bus.o1[k]) + int'(bus.o2[k]) + int'(bus.o3[k]);
        if (n != 1) oh_err++;
        w[2*k +: 2] = bus.o1[k] ? 2'd1 : bus.o2[k] ? 2'd2 : bus.o3[k] ? 2'd3 : 2'd0;
      end
      if (!prev_any) dec_q.push_back(w);
    end
    if (bus.o4) begin
      eof_cyc++;
      if (any) oh_err++;
      if (!prev_o4) eof_cnt++;
    end
    if (cur !== prev) rail_chg++;
    if (bus.busy && bus.in_ready) rdy_busy++;
    prev = cur; prev_any = any; prev_o4 = bus.o4;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en) mon_sample();
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 60 && !bus.in_ready; i++) tick();
    check({tag, "_ready"}, bus.in_ready, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 120 && bus.busy; i++) tick();
    check({tag, "_idle"}, bus.busy, 0);
    tick();
  endtask

  // Presents a word and returns on the negedge just after the accept edge.
  task automatic send_word(input logic [31:0] d, input logic eop, input string tag);
    bus.in_data  = d;
    bus.in_eop   = eop;
    bus.in_valid = 1'b1;
    wait_ready(tag);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [64:0] exp_r;
  int          t_acc[3];
  logic [31:0] words[3];

  initial begin
    bus.in_data  = '0;
    bus.in_eop   = 1'b0;
    bus.in_valid = 1'b0;
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_0000;
    words[2] = 32'hA5A5_A5A5;

    // Reset state
    repeat (2) tick();
    check("rst_rails", {bus.o3, bus.o2, bus.o1, bus.o0, bus.o4}, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.pkt_cnt, 0);
    rst = 1'b0;
    #1 check("ready_before_edge", bus.in_ready, 0);
    tick();
    check("ready_after_release", bus.in_ready, 1);

    // One-word packet 0x1B, exact per-cycle rail sequence
    mon_reset();
    mon_en = 1'b1;
    bus.in_data  = 32'h0000_001B;
    bus.in_eop   = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1) bus.in_valid = 1'b0;
      if (i <= 3) exp_r = {16'h0001, 16'h0002, 16'h0004, 16'hFFF8, 1'b0};
      else if (i >= 7 && i <= 9) exp_r = 65'h1;
      else exp_r = '0;
      check($sformatf("t1_rails_c%0d", i), {bus.o3, bus.o2, bus.o1, bus.o0, bus.o4}, exp_r);
      if (i == 12) check("t1_cnt_before", bus.pkt_cnt, 0);
    end
    check("t1_cnt_final", bus.pkt_cnt, 1);
    check("t1_busy_final", bus.busy, 0);

    // Three-word packet with in_valid held high
    mon_reset();
    for (int w = 0; w < 3; w++) begin
      bus.in_data  = words[w];
      bus.in_eop   = (w == 2);
      bus.in_valid = 1'b1;
      wait_ready($sformatf("t2_w%0d", w));
      t_acc[w] = cyc;
      tick();
    end
    bus.in_valid = 1'b0;
    wait_idle("t2");
    check("t2_gap01", t_acc[1] - t_acc[0], 8);
    check("t2_gap12", t_acc[2] - t_acc[1], 8);
    check("t2_onehot", oh_err, 0);
    check("t2_eof_tokens", eof_cnt, 1);
    check("t2_flits", dec_q.size(), 3);
    for (int w = 0; w < 3 && w < dec_q.size(); w++)
      check($sformatf("t2_word%0d", w), dec_q[w], words[w]);
    check("t2_cnt", bus.pkt_cnt, 2);

    // Ack delayed 10 cycles in every phase
    ack_mode = 1;
    mon_reset();
    send_word(32'h1234_5678, 1'b1, "t3");
    bus.in_valid = 1'b0;
    wait_idle("t3");
    check("t3_data_cycles", data_cyc, 13);
    check("t3_eof_cycles", eof_cyc, 13);
    check("t3_rail_changes", rail_chg, 4);
    check("t3_ready_while_busy", rdy_busy, 0);
    check("t3_onehot", oh_err, 0);
    check("t3_word", (dec_q.size() > 0) ? dec_q[0] : 32'hDEAD_BEEF, 32'h1234_5678);
    check("t3_ready_back", bus.in_ready, 1);
    ack_mode = 0;
    mon_en = 1'b0;

    // Stale ack held high across reset release
    ack_mode = 2;
    ia_man   = 1'b1;
    rst      = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("t4_stale_ready", bus.in_ready, 0);
    check("t4_stale_busy", bus.busy, 0);
    begin
      int hi = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (bus.in_ready) hi++;
      end
      check("t4_stale_ready_cycles", hi, 0);
    end
    ia_man = 1'b0;
    tick();
    check("t4_ready_c1", bus.in_ready, 0);
    tick();
    check("t4_ready_c2", bus.in_ready, 0);
    tick();
    check("t4_ready_c3", bus.in_ready, 1);
    ack_mode = 0;

    // Reset pulsed while the eof token is on the rail
    send_word(32'h0000_00C3, 1'b1, "t5a");
    bus.in_valid = 1'b0;
    wait_idle("t5a");
    check("t5_cnt_pre", bus.pkt_cnt, 1);
    send_word(32'h0F0F_0F0F, 1'b1, "t5b");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.o4; i++) tick();
    check("t5_eof_seen", bus.o4, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_o4", bus.o4, 0);
    check("t5_async_cnt", bus.pkt_cnt, 0);
    check("t5_async_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    send_word(32'h8765_4321, 1'b1, "t5c");
    bus.in_valid = 1'b0;
    wait_idle("t5c");
    check("t5_cnt_after", bus.pkt_cnt, 1);

    // Counter wrap from 0xFFFF
    force dut.pkt_cnt_q = 16'hFFFF;
    tick();
    release dut.pkt_cnt_q;
    tick();
    check("t6_preload", bus.pkt_cnt, 16'hFFFF);
    send_word(32'h0000_0001, 1'b1, "t6");
    bus.in_valid = 1'b0;
    wait_idle("t6");
    check("t6_wrap", bus.pkt_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
